// File: rtl/fp_pkg.sv
// Shared floating-point definitions: FSM states, flag bit positions and
// operand classification used by the sequential FP datapaths.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam int MAX_EXP_W  = 16;
  localparam int MAX_FRAC_W = 64;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
  } fp_class_t;

  // Fields arrive zero-extended to the maximum widths so one function serves
  // every format; subnormals (exp==0) are treated as zero.
  function automatic fp_class_t fp_classify(input logic [MAX_EXP_W-1:0]  e,
                                            input logic [MAX_FRAC_W-1:0] f,
                                            input int                    exp_w,
                                            input int                    frac_w);
    fp_class_t              c;
    logic [MAX_EXP_W-1:0]   ones;
    logic [MAX_FRAC_W-1:0]  top;
    ones   = (MAX_EXP_W'(1) << exp_w) - MAX_EXP_W'(1);
    top    = f >> (frac_w - 1);
    c.zero = (e == '0);
    c.inf  = (e == ones) && (f == '0);
    c.nan  = (e == ones) && (f != '0);
    c.snan = c.nan && !top[0];
    return c;
  endfunction

endpackage

// File: rtl/fpmul_seq_norm.sv
// Combinational normalise, round-toward-zero and special-case selection for
// the final stage of the sequential multiplier.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  logic                      sign,
  input  logic signed [EXP_W+1:0]   exp_sum,
  input  logic [2*FRAC_W+1:0]       prod,
  input  fp_class_t                 x_cls,
  input  fp_class_t                 y_cls,
  output logic [EXP_W+FRAC_W:0]     result,
  output logic [3:0]                flags
);

  localparam int SIG_W = FRAC_W + 1;
  localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);

  logic                    prod_msb;
  logic [SIG_W-1:0]        sig;
  logic                    sticky;
  logic signed [EXP_W+1:0] exp_n;
  logic                    is_nan;
  logic                    inv_op;

  assign prod_msb = prod[2*SIG_W-1];
  assign is_nan   = x_cls.nan || y_cls.nan || (x_cls.inf && y_cls.zero) ||
                    (y_cls.inf && x_cls.zero);
  assign inv_op   = x_cls.snan || y_cls.snan || (x_cls.inf && y_cls.zero) ||
                    (y_cls.inf && x_cls.zero);

  // NOTE: every output gets a default before the priority chain so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    sig    = prod_msb ? prod[2*SIG_W-1:SIG_W] : prod[2*SIG_W-2:SIG_W-1];
    sticky = prod_msb ? |prod[SIG_W-1:0]      : |prod[SIG_W-2:0];
    exp_n  = prod_msb ? exp_sum + (EXP_W+2)'(1) : exp_sum;
    result = {sign, exp_n[EXP_W-1:0], sig[FRAC_W-1:0]};
    flags  = '0;
    flags[FLG_NX] = sticky;

    if (is_nan) begin
      result        = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
      flags         = '0;
      flags[FLG_NV] = inv_op;
    end else if (x_cls.inf || y_cls.inf) begin
      result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags  = '0;
    end else if (x_cls.zero || y_cls.zero) begin
      result = {sign, {(EXP_W+FRAC_W){1'b0}}};
      flags  = '0;
    end else if (!exp_n[EXP_W+1] && (exp_n >= EXP_MAX)) begin
      // RZ overflow saturates to the largest finite value, not infinity.
      result        = {sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
      flags         = '0;
      flags[FLG_OF] = 1'b1;
      flags[FLG_NX] = 1'b1;
    end else if (exp_n[EXP_W+1] || (exp_n == '0)) begin
      result        = {sign, {(EXP_W+FRAC_W){1'b0}}};
      flags         = '0;
      flags[FLG_UF] = 1'b1;
      flags[FLG_NX] = 1'b1;
    end
  end

endmodule

// File: rtl/fpmul_seq.sv
// Multicycle floating-point multiplier: radix-2 shift-add significand product,
// one bit per cycle, followed by a single normalise/round stage.
module fpmul_seq
  import fp_pkg::*;
#(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] x,
  input  logic [EXP_W+FRAC_W:0] y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] result,
  output logic [3:0]            flags
);

  localparam int SIG_W = FRAC_W + 1;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int CNT_W = $clog2(SIG_W);
  localparam int W     = 1 + EXP_W + FRAC_W;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [2*SIG_W-1:0]      acc_q, acc_d;
  logic [SIG_W-1:0]        xsig_q, xsig_d, ysig_q, ysig_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W+1:0] exp_sum_q, exp_sum_d;
  fp_class_t               xcls_q, xcls_d, ycls_q, ycls_d;
  logic [W-1:0]            result_q, result_d;
  logic [3:0]              flags_q, flags_d;

  logic [W-1:0]            norm_result;
  logic [3:0]              norm_flags;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;

  fp_norm_round #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_norm (
    .sign    (sign_q),
    .exp_sum (exp_sum_q),
    .prod    (acc_q),
    .x_cls   (xcls_q),
    .y_cls   (ycls_q),
    .result  (norm_result),
    .flags   (norm_flags)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    xsig_d    = xsig_q;
    ysig_d    = ysig_q;
    sign_d    = sign_q;
    exp_sum_d = exp_sum_q;
    xcls_d    = xcls_q;
    ycls_d    = ycls_q;
    result_d  = result_q;
    flags_d   = flags_q;

    unique case (state_q)
      IDLE: if (in_valid) begin
        sign_d    = x[W-1] ^ y[W-1];
        exp_sum_d = $signed({2'b00, x[W-2:FRAC_W]}) + $signed({2'b00, y[W-2:FRAC_W]})
                    - $signed((EXP_W+2)'(BIAS));
        xsig_d    = {1'b1, x[FRAC_W-1:0]};
        ysig_d    = {1'b1, y[FRAC_W-1:0]};
        xcls_d    = fp_classify(MAX_EXP_W'(x[W-2:FRAC_W]), MAX_FRAC_W'(x[FRAC_W-1:0]),
                                EXP_W, FRAC_W);
        ycls_d    = fp_classify(MAX_EXP_W'(y[W-2:FRAC_W]), MAX_FRAC_W'(y[FRAC_W-1:0]),
                                EXP_W, FRAC_W);
        acc_d     = '0;
        count_d   = '0;
        state_d   = MULT;
      end
      MULT: begin
        if (ysig_q[count_q])
          acc_d = acc_q + ({{SIG_W{1'b0}}, xsig_q} << count_q);
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(SIG_W - 1))
          state_d = NORM;
      end
      NORM: begin
        result_d = norm_result;
        flags_d  = norm_flags;
        state_d  = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and every flop is reset, so an
  // operation interrupted by rst_n leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      xsig_q    <= '0;
      ysig_q    <= '0;
      sign_q    <= 1'b0;
      exp_sum_q <= '0;
      xcls_q    <= '0;
      ycls_q    <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      xsig_q    <= xsig_d;
      ysig_q    <= ysig_d;
      sign_q    <= sign_d;
      exp_sum_q <= exp_sum_d;
      xcls_q    <= xcls_d;
      ycls_q    <= ycls_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

endmodule

// File: tb/tb_fpmul_seq.sv
// Directed bench for fpmul_seq (binary16): hand-computed products, latency,
// backpressure and mid-operation reset.
module tb_fpmul_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  int total;
  int bad;

  fpmul_seq #(.EXP_W(5), .FRAC_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one operation, checks latency, the product and flags, optional
  // backpressure hold, then drains the result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input logic [3:0] exp_flg,
                        input int hold);
    int   edges;
    logic busy_ok;
    logic [15:0] r0;
    logic [3:0]  f0;
    logic stable;
    @(negedge clk);
    check({tag, " in_ready before"}, {31'd0, in_ready}, 32'd1);
    x = a;
    y = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    edges   = 0;
    busy_ok = 1'b1;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (in_ready) busy_ok = 1'b0;
    end
    check({tag, " latency"}, edges, 12);
    check({tag, " in_ready low while busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " result"}, {16'd0, result}, {16'd0, exp_res});
    check({tag, " flags"}, {28'd0, flags}, {28'd0, exp_flg});
    if (hold > 0) begin
      r0 = result;
      f0 = flags;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        if (!out_valid || in_ready || result !== r0 || flags !== f0) stable = 1'b0;
      end
      check({tag, " held under backpressure"}, {31'd0, stable}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " out_valid drops"}, {31'd0, out_valid}, 32'd0);
    check({tag, " back to idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int   edges;
    logic quiet;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    #12;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", {16'd0, result}, 32'd0);
    check("reset flags", {28'd0, flags}, 32'd0);
    rst_n = 1'b1;
    #3;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);

    run_op("1.0*1.0",     16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 0);
    run_op("1.5*1.5",     16'h3E00, 16'h3E00, 16'h4080, 4'b0000, 0);
    run_op("nx trunc",    16'h3C01, 16'h3C01, 16'h3C02, 4'b0001, 0);
    run_op("overflow",    16'h7BFF, 16'h7BFF, 16'h7BFF, 4'b0101, 0);
    run_op("underflow",   16'h0400, 16'h0400, 16'h0000, 4'b0011, 0);
    run_op("neg min norm",16'hBC00, 16'h0400, 16'h8400, 4'b0000, 0);
    run_op("inf*zero",    16'h7C00, 16'h0000, 16'h7E00, 4'b1000, 0);
    run_op("qnan*1",      16'h7E00, 16'h3C00, 16'h7E00, 4'b0000, 0);
    run_op("-inf*1",      16'hFC00, 16'h3C00, 16'hFC00, 4'b0000, 0);
    run_op("snan*1",      16'h7D00, 16'h3C00, 16'h7E00, 4'b1000, 0);
    run_op("backpressure",16'h3E00, 16'h3E00, 16'h4080, 4'b0000, 5);
    run_op("after bp",    16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 0);

    // Leave a nonzero result registered, then abort an op at count 5.
    run_op("pre-reset",   16'h7BFF, 16'h7BFF, 16'h7BFF, 4'b0101, 0);
    @(negedge clk);
    x = 16'h3C00;
    y = 16'h3C00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
    check("mid reset result", {16'd0, result}, 32'd0);
    check("mid reset flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    quiet = 1'b1;
    for (edges = 0; edges < 15; edges++) begin
      @(posedge clk);
      #1;
      if (out_valid) quiet = 1'b0;
    end
    check("abandoned op silent", {31'd0, quiet}, 32'd1);
    run_op("post reset",  16'h3E00, 16'h3E00, 16'h4080, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpmul_seq.md
Name: fpmul_seq

Overview:
- Multicycle, parametrised IEEE-754-style floating-point multiplier; successor to the combinational half-precision multiply path in the fma16 unit.
- Format set by EXP_W/FRAC_W; default is binary16.
- The significand product is built one bit per cycle with a radix-2 shift-add; special cases, flags and round-toward-zero (RZ) are handled as specified below.
- valid/ready handshakes on both sides let it sit between an operand issue stage and the result writeback.

Parameters:
- EXP_W, 5, exponent field width.
- FRAC_W, 10, stored fraction width; SIG_W = FRAC_W+1 (hidden bit included).
- BIAS, 2**(EXP_W-1)-1, exponent bias (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands x, y are valid.
- in_ready  out  1  block can accept operands.
- x  in  1+EXP_W+FRAC_W  multiplicand {sign, exp, frac}.
- y  in  1+EXP_W+FRAC_W  multiplier.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  1+EXP_W+FRAC_W  product, RZ-rounded.
- flags  out  4  {NV, OF, UF, NX}, bit 3 down to bit 0; valid with out_valid.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; result=0; flags=0; internal accumulator/counter cleared.
  - Reset mid-operation abandons the operation; no output is produced for it.
- States: IDLE, MULT, NORM, DONE.
- in_ready = (state==IDLE), a combinational function of the state only.
- Acceptance: edge where in_valid & in_ready.
  - Latch sign = xs^ys.
  - Latch exp_sum = xe+ye-BIAS, signed, width EXP_W+2.
  - Latch both significands as {1,frac}.
  - Latch class bits: zero (exp==0, so subnormals count as zero), inf, NaN.
  - Clear the 2*SIG_W-bit accumulator; count=0; go to MULT.
- MULT, one edge per multiplier bit, LSB first:
  - If bit[count]=1, add Xsig<<count into the accumulator.
  - count++; after SIG_W edges go to NORM.
- NORM, one edge; all of the following is registered into result/flags, then go to DONE with out_valid=1:
  - If product bit[2*SIG_W-1]=1: take the top SIG_W bits, exp=exp_sum+1. Otherwise take the next SIG_W bits, exp=exp_sum.
  - NX = any discarded product bit set. Truncate (RZ).
  - Special-case priority, highest first:
    - NaN operand, or inf*zero: result = canonical qNaN {0, all-ones exp, 1 followed by zeros}. Flags: NV only, and only when inf*zero or a signalling NaN is present (frac MSB=0).
    - Inf operand: signed infinity, flags 0.
    - Zero operand: signed zero, flags 0.
    - exp >= 2**EXP_W-1: max finite magnitude {sign, all-ones-minus-1 exp, all-ones frac}; OF=1, NX=1.
    - exp <= 0: signed zero (flush, no subnormal outputs); UF=1, NX=1.
    - Otherwise: normal result.
- Latency is fixed and data-independent, special cases included: out_valid rises SIG_W+1 edges after the acceptance edge (12 for defaults).
- DONE:
  - result/flags held stable while out_valid=1 and out_ready=0.
  - On the out_ready edge: out_valid=0, go to IDLE.
  - New operands are never accepted in the same edge (one op in flight; initiation interval ≥ SIG_W+3).
- out_ready is ignored outside DONE; in_valid is ignored outside IDLE.

Decomposition:
- Package fp_pkg holds:
  - the state enum (IDLE/MULT/NORM/DONE);
  - flag bit index constants (FLG_NV=3, FLG_OF=2, FLG_UF=1, FLG_NX=0);
  - a classification function (zero/inf/nan/snan) parametrised by field widths, shared later with a sequential adder.
- One sub-module is natural: fp_norm_round, the combinational normalise + RZ + special-case mux used by the NORM stage. The FSM and shift-add datapath stay in the top module.

Test Plan:
- 0x3C00 * 0x3C00 (1.0*1.0) -> result 0x3C00, flags 0000, out_valid exactly 12 edges after acceptance; in_ready low throughout.
- 0x3E00 * 0x3E00 (1.5*1.5) -> 0x4080, flags 0000. 0x3C01 * 0x3C01 -> 0x3C02, flags 0001 (NX from truncation).
- 0x7BFF * 0x7BFF -> 0x7BFF, flags 0101 (OF,NX). 0x0400 * 0x0400 -> 0x0000, flags 0011 (UF,NX). 0xBC00 * 0x0400 -> 0x8400, flags 0000.
- 0x7C00 * 0x0000 -> 0x7E00, flags 1000. 0x7E00 * 0x3C00 -> 0x7E00, flags 0000. 0xFC00 * 0x3C00 -> 0xFC00, flags 0000.
- Backpressure: out_ready held 0 for 5 cycles after out_valid -> result/flags stable, in_ready stays 0; out_ready=1 -> IDLE on the next edge, and the next op is accepted after it.
- Reset: assert rst_n=0 at MULT count=5 -> immediately out_valid=0, result=0, flags=0, in_ready=1 after release. A fresh 0x3E00*0x3E00 then yields 0x4080.
